// File: rtl/starwars_divide_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock, MSB first,
// start/busy/done handshake; results feed the downstream parallel-load shift bank.
module starwars_divide_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_q;
    // Partial remainder. Its top bit never feeds the next shift, so only
    // the low WIDTH bits are kept; the full WIDTH+1-bit value exists in w_rs.
    logic [WIDTH-1:0] r_r;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH:0]   w_rs;
    logic             w_ge;
    logic [WIDTH-1:0] w_sub;
    logic [WIDTH-1:0] w_r_next;
    logic [WIDTH-1:0] w_q_next;

    // One restoring step: shift in the next dividend bit, trial-subtract, keep or restore.
    assign w_rs     = {r_r, r_q[WIDTH-1]};
    assign w_ge     = (w_rs >= {1'b0, r_d});
    assign w_sub    = w_rs[WIDTH-1:0] - r_d;
    assign w_r_next = w_ge ? w_sub : w_rs[WIDTH-1:0];
    assign w_q_next = {r_q[WIDTH-2:0], w_ge};

    // Control FSM, datapath registers and registered result outputs.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state   <= S_IDLE;
            r_d       <= '0;
            r_q       <= '0;
            r_r       <= '0;
            r_cnt     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_d      <= divisor;
                        r_q      <= dividend;
                        r_r      <= '0;
                        r_cnt    <= '0;
                        busy     <= 1'b1;
                        div_zero <= (divisor == '0);
                        r_state  <= S_RUN;
                    end else begin
                        r_state  <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_q   <= w_q_next;
                    r_r   <= w_r_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_CNT) begin
                        quotient  <= w_q_next;
                        remainder <= w_r_next;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_starwars_divide_seq.sv
// Directed and randomized checks of starwars_divide_seq against an arithmetic reference.
module tb_starwars_divide_seq;

    localparam int unsigned W = 16;

    logic         clk;
    logic         clr_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;

    int n_checks = 0;
    int n_fail   = 0;

    starwars_divide_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue a start (caller is at a falling edge); returns at the falling edge after T0.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        dividend = $urandom();
        divisor  = $urandom();
    endtask

    // Waits for done counting falling edges after T0; optionally injects a start at edge inj_at.
    task automatic wait_done(output int lat, output int busy_cnt, input int inj_at,
                             input logic [W-1:0] ia, input logic [W-1:0] ib);
        lat      = 0;
        busy_cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            if (i > 1) @(negedge clk);
            if (i == inj_at + 1) start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                lat = i;
                break;
            end
            if (i == inj_at) begin
                start    = 1'b1;
                dividend = ia;
                divisor  = ib;
            end
        end
        start = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        eq = (b == '0) ? '1 : W'(a / b);
        er = (b == '0) ? a  : W'(a % b);
        chk({tag, " quotient"}, 32'(quotient), 32'(eq));
        chk({tag, " remainder"}, 32'(remainder), 32'(er));
        chk({tag, " div_zero"}, 32'(div_zero), 32'(b == '0));
    endtask

    initial begin
        int           lat;
        int           bcnt;
        int           stray;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        clr_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);

        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset quotient", 32'(quotient), 32'd0);
        chk("reset remainder", 32'(remainder), 32'd0);
        chk("reset div_zero", 32'(div_zero), 32'd0);
        clr_n = 1'b1;
        @(negedge clk);

        // 100 / 7 with latency and pulse width checks
        start_op(16'd100, 16'd7);
        chk("100/7 busy after T0", 32'(busy), 32'd1);
        wait_done(lat, bcnt, 0, '0, '0);
        chk("100/7 latency", 32'(lat), 32'd17);
        chk("100/7 busy cycles", 32'(bcnt), 32'd16);
        check_result("100/7", 16'd100, 16'd7);
        @(negedge clk);
        chk("100/7 done width", 32'(done), 32'd0);

        start_op(16'hFFFF, 16'd1);
        wait_done(lat, bcnt, 0, '0, '0);
        chk("FFFF/1 latency", 32'(lat), 32'd17);
        check_result("FFFF/1", 16'hFFFF, 16'd1);
        @(negedge clk);

        start_op(16'h1234, 16'h1235);
        wait_done(lat, bcnt, 0, '0, '0);
        check_result("1234/1235", 16'h1234, 16'h1235);
        @(negedge clk);

        start_op(16'h00A5, 16'd0);
        wait_done(lat, bcnt, 0, '0, '0);
        chk("A5/0 latency", 32'(lat), 32'd17);
        check_result("A5/0", 16'h00A5, 16'd0);
        @(negedge clk);

        // Start while busy must be ignored
        start_op(16'd100, 16'd7);
        wait_done(lat, bcnt, 5, 16'd9, 16'd3);
        chk("ignored start latency", 32'(lat), 32'd17);
        check_result("ignored start", 16'd100, 16'd7);
        stray = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (done || busy) stray++;
        end
        chk("ignored start extra activity", 32'(stray), 32'd0);

        // Asynchronous reset mid-run
        start_op(16'd1000, 16'd10);
        repeat (8) @(posedge clk);
        #2 clr_n = 1'b0;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort quotient", 32'(quotient), 32'd0);
        chk("abort remainder", 32'(remainder), 32'd0);
        @(posedge clk);
        #2 clr_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done || busy) stray++;
        end
        chk("abort no done", 32'(stray), 32'd0);
        start_op(16'd1000, 16'd10);
        wait_done(lat, bcnt, 0, '0, '0);
        check_result("1000/10", 16'd1000, 16'd10);

        // Back-to-back start in the DONE cycle
        start_op(16'd50000, 16'd300);
        chk("b2b busy", 32'(busy), 32'd1);
        chk("b2b held quotient", 32'(quotient), 32'd100);
        chk("b2b held remainder", 32'(remainder), 32'd0);
        repeat (8) @(negedge clk);
        chk("b2b mid quotient", 32'(quotient), 32'd100);
        wait_done(lat, bcnt, 0, '0, '0);
        chk("b2b latency", 32'(lat), 32'd9);
        check_result("50000/300", 16'd50000, 16'd300);
        chk("50000/300 literal quotient", 32'(quotient), 32'd166);
        chk("50000/300 literal remainder", 32'(remainder), 32'd200);
        @(negedge clk);

        // Randomized operands against plain arithmetic
        for (int n = 0; n < 24; n++) begin
            ra = W'($urandom());
            case ($urandom_range(0, 3))
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 15));
                2:       rb = ra + W'($urandom_range(0, 3));
                default: rb = W'($urandom());
            endcase
            start_op(ra, rb);
            wait_done(lat, bcnt, 0, '0, '0);
            chk("rand latency", 32'(lat), 32'd17);
            check_result("rand", ra, rb);
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/starwars_divide_seq.md
Name: starwars_divide_seq

Overview:
- Sequential unsigned shift-and-subtract divider feeding the 8-bit 74299-style universal shift-register stage.
- The quotient and remainder words are loaded in parallel into the downstream shift-register bank (S1=S0=1) and then shifted out to the CPU/math path.
- Restoring division, one quotient bit per clock, MSB first, with a start/busy/done handshake.

Parameters:
WIDTH, 16, operand/result width in bits; legal range 8..32.

Ports:
clk  input  1  system clock; all state changes on rising edge.
clr_n  input  1  asynchronous active-low reset; clears all state and outputs.
start  input  1  request pulse; sampled only in IDLE or DONE.
dividend  input  WIDTH  numerator; captured on the accepted start edge.
divisor  input  WIDTH  denominator; captured on the accepted start edge.
busy  output  1  high while iterating.
done  output  1  single-cycle pulse when results become valid.
quotient  output  WIDTH  result; held stable from done until the next accepted start.
remainder  output  WIDTH  result; same validity as quotient.
div_zero  output  1  divisor captured as zero; same validity as quotient.

Behaviour:
- Reset (clr_n low, asynchronous): state=IDLE; busy=0, done=0, div_zero=0, quotient=0, remainder=0; iteration counter=0.
  - Release takes effect on the next rising edge.
  - Reset asserted mid-RUN aborts the operation with no done pulse.
- States:
  - IDLE --start--> RUN.
  - RUN --(counter==WIDTH-1)--> DONE.
  - DONE --> IDLE after one cycle, or DONE --start--> RUN directly (back-to-back).
- Accepted start, edge T0:
  - Latch divisor into the D register.
  - Load the working quotient register Q with dividend.
  - Clear the partial remainder R (WIDTH+1 bits).
  - Counter=0; busy=1 from T0+; div_zero=(divisor==0) latched; done=0.
- Each RUN edge:
  - Rs = {R[WIDTH-1:0], Q[WIDTH-1]}.
  - If Rs >= {1'b0,D}: R = Rs - D and Q = {Q[WIDTH-2:0],1}; else R = Rs and Q = {Q[WIDTH-2:0],0}.
  - Counter increments.
- Edge on which counter==WIDTH-1:
  - The final iteration executes.
  - quotient=Q_next, remainder=R_next[WIDTH-1:0].
  - busy=0, done=1, state=DONE.
- Latency: done is high in the cycle following edge T0+WIDTH (exactly WIDTH RUN edges).
- start while busy is ignored; operand inputs are don't-care during RUN.
- Divide by zero:
  - No special path; the algorithm runs naturally.
  - Result: quotient = all ones, remainder = dividend, div_zero=1, same latency.
- Dividend < divisor: quotient=0, remainder=dividend.
- Output registers change only on the completion edge and on reset. A new start does not clear them until its own completion.
- The comparison is WIDTH+1 bits wide; no overflow is possible. Remainder < divisor whenever divisor != 0.

Test Plan:
- Reset, then start with dividend=100, divisor=7 (WIDTH=16) -> busy=1 for 16 cycles; done pulses 1 cycle at T0+17; quotient=14, remainder=2, div_zero=0.
- dividend=0xFFFF, divisor=1 -> quotient=0xFFFF, remainder=0; then dividend=0x1234, divisor=0x1235 -> quotient=0, remainder=0x1234.
- dividend=0x00A5, divisor=0 -> quotient=0xFFFF, remainder=0x00A5, div_zero=1, done at the same latency.
- Start 100/7, pulse start with 9/3 at T0+5 -> second request ignored; result remains 14 r 2; only one done pulse.
- Start 1000/10, drop clr_n at T0+8 for 1 cycle (asynchronously, mid-clock) -> busy, done and outputs are 0 immediately; no done pulse afterwards; a new start of 1000/10 then yields 100 r 0.
- Start asserted in the DONE cycle with 50000/300 -> accepted; busy high the next cycle; previous outputs held until the new done; result 166 r 200.
